// File: rtl/uart_line_rx_pkg.sv
// rtl/uart_line_rx_pkg.sv - shared types for the line-framing UART receiver

package uart_line_rx_pkg;

    typedef enum logic [1:0] {
        PAR_NONE,
        PAR_EVEN,
        PAR_ODD
    } parity_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } rx_state_e;

    typedef struct packed {
        logic       eol;
        logic       perr;
        logic       ferr;
        logic [7:0] data;
    } rx_entry_t;

endpackage

// File: rtl/uart_line_rx_fifo.sv
// rtl/uart_line_rx_fifo.sv - byte FIFO with sticky overflow and synchronous clear

module uart_line_rx_fifo #(
    parameter int  Depth   = 16,
    parameter type entry_t = logic [10:0]
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     clear_i,
    input  logic                     push,
    input  entry_t                   push_data,
    output logic                     push_ok,
    input  logic                     pop,
    output entry_t                   head,
    output logic                     valid,
    output logic [$clog2(Depth):0]   fill,
    output logic                     overflow
);
    localparam int AW = $clog2(Depth);

    entry_t        mem [Depth];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          full;
    logic          do_pop;

    assign full    = (count == (AW+1)'(Depth));
    assign valid   = (count != '0);
    assign do_pop  = pop && valid;
    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign push_ok = push && (!full || do_pop);
    assign head    = valid ? mem[rd_ptr] : '0;
    assign fill    = count;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else if (clear_i) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
            if (push && !push_ok) overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok && !clear_i) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/uart_line_rx.sv
// rtl/uart_line_rx.sv - oversampling UART receiver with end-of-line tagging and output FIFO

module uart_line_rx
    import uart_line_rx_pkg::*;
#(
    parameter int         DataBits   = 8,
    parameter parity_e    ParityMode = PAR_NONE,
    parameter int         StopBits   = 1,
    parameter int         Oversample = 16,
    parameter int         DivWidth   = 16,
    parameter int         FifoDepth  = 16,
    parameter logic [7:0] LineChar   = 8'h0A,
    parameter int         MaxLineLen = 80
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [DivWidth-1:0]          div_i,
    input  logic                         clear_i,
    input  logic                         rx_i,
    output logic [7:0]                   data_o,
    output logic                         eol_o,
    output logic                         parity_err_o,
    output logic                         frame_err_o,
    output logic                         valid_o,
    input  logic                         ready_i,
    output logic                         overflow_o,
    output logic [$clog2(FifoDepth):0]   fill_o
);
    localparam int OsW = $clog2(Oversample);
    localparam int LcW = $clog2(MaxLineLen + 1);

    logic                rx_meta;
    logic                rxs;
    logic                rxs_d;
    rx_state_e           state;
    rx_state_e           state_d;
    logic [DivWidth-1:0] div_cnt;
    logic [OsW-1:0]      os_cnt;
    logic [2:0]          bit_cnt;
    logic [7:0]          shreg;
    logic                par;
    logic                ferr;
    logic [LcW-1:0]      line_cnt;
    logic                fall;
    logic                tick;
    logic                sample;
    logic                push;
    logic                push_ok;
    rx_entry_t           entry;
    rx_entry_t           head;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
            rxs_d   <= 1'b1;
        end else begin
            rx_meta <= rx_i;
            rxs     <= rx_meta;
            rxs_d   <= rxs;
        end
    end

    assign fall   = rxs_d & ~rxs;
    assign tick   = (state != ST_IDLE) && (div_cnt == div_i);
    // The start bit is judged at its centre; every later sample is one full bit on.
    assign sample = tick && (os_cnt == ((state == ST_START) ? OsW'(Oversample / 2 - 1)
                                                            : OsW'(Oversample - 1)));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            div_cnt <= '0;
            os_cnt  <= '0;
        end else begin
            if (clear_i || state == ST_IDLE || tick) div_cnt <= '0;
            else                                     div_cnt <= div_cnt + 1'b1;
            if (clear_i || state == ST_IDLE || sample) os_cnt <= '0;
            else if (tick)                             os_cnt <= os_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)        state <= ST_IDLE;
        else if (clear_i) state <= ST_IDLE;
        else              state <= state_d;
    end

    always_comb begin
        state_d = state;
        push    = 1'b0;
        case (state)
            ST_IDLE:   if (fall) state_d = ST_START;
            ST_START:  if (sample) state_d = rxs ? ST_IDLE : ST_DATA;
            ST_DATA:   if (sample && bit_cnt == 3'(DataBits - 1))
                           state_d = (ParityMode == PAR_NONE) ? ST_STOP : ST_PARITY;
            ST_PARITY: if (sample) state_d = ST_STOP;
            ST_STOP:   if (sample && bit_cnt == 3'(StopBits - 1)) begin
                           state_d = ST_IDLE;
                           push    = 1'b1;
                       end
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            bit_cnt <= '0;
            shreg   <= '0;
            par     <= 1'b0;
            ferr    <= 1'b0;
        end else if (sample) begin
            case (state)
                ST_START: begin
                    bit_cnt <= '0;
                    shreg   <= '0;
                    par     <= 1'b0;
                    ferr    <= 1'b0;
                end
                ST_DATA: begin
                    shreg[bit_cnt] <= rxs;
                    par            <= par ^ rxs;
                    bit_cnt        <= (bit_cnt == 3'(DataBits - 1)) ? 3'd0 : bit_cnt + 3'd1;
                end
                ST_PARITY: par <= par ^ rxs;
                ST_STOP: begin
                    ferr    <= ferr | ~rxs;
                    bit_cnt <= bit_cnt + 3'd1;
                end
                default: ;
            endcase
        end
    end

    // The last stop sample is folded in combinationally so the push needs no extra cycle.
    always_comb begin
        entry      = '0;
        entry.data = shreg;
        entry.ferr = ferr | ~rxs;
        case (ParityMode)
            PAR_EVEN: entry.perr = par;
            PAR_ODD:  entry.perr = ~par;
            default:  entry.perr = 1'b0;
        endcase
        entry.eol = (shreg == LineChar) || (line_cnt == LcW'(MaxLineLen - 1));
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)        line_cnt <= '0;
        else if (clear_i) line_cnt <= '0;
        else if (push_ok) line_cnt <= entry.eol ? '0 : line_cnt + 1'b1;
    end

    uart_line_rx_fifo #(
        .Depth   (FifoDepth),
        .entry_t (rx_entry_t)
    ) u_fifo (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .clear_i   (clear_i),
        .push      (push),
        .push_data (entry),
        .push_ok   (push_ok),
        .pop       (ready_i),
        .head      (head),
        .valid     (valid_o),
        .fill      (fill_o),
        .overflow  (overflow_o)
    );

    assign data_o       = head.data;
    assign eol_o        = head.eol;
    assign parity_err_o = head.perr;
    assign frame_err_o  = head.ferr;

endmodule

// File: doc/uart_line_rx.md
# uart_line_rx

Parametrised, synthesizable UART receiver with line framing. It is the next generation of the bench-side UART byte reader, moved into RTL for SoC peripherals and on-chip debug capture. It oversamples `rx_i`, decodes configurable frames (parity mode, one or two stop bits), and tags end-of-line bytes (`LineChar` or `MaxLineLen` overflow). Bytes are buffered in a FIFO behind a valid/ready stream port.

## Interface
- Clocking: one clock. Reset is asynchronous and active-high.
- `DataBits`, default 8: data bits per frame, legal 5..8, LSB first.
- `ParityMode`, default `PAR_NONE`: `PAR_NONE`, `PAR_EVEN` or `PAR_ODD`.
- `StopBits`, default 1: legal 1 or 2.
- `Oversample`, default 16: ticks per bit, even, ≥4.
- `DivWidth`, default 16: width of `div_i`.
- `FifoDepth`, default 16: power of 2, ≥2.
- `LineChar`, default 8'h0A: end-of-line character.
- `MaxLineLen`, default 80: forces EOL after this many bytes without `LineChar`.
- `clk_i`  in  1  clock.
- `rst_i`  in  1  asynchronous active-high reset.
- `div_i`  in  DivWidth  tick period minus 1, in `clk_i` cycles. Static while idle.
- `clear_i`  in  1  synchronous flush.
- `rx_i`  in  1  serial input, asynchronous, idle high.
- `data_o`  out  8  received byte, zero-extended above `DataBits`.
- `eol_o`  out  1  byte terminates a line.
- `parity_err_o`  out  1  parity mismatch on this byte.
- `frame_err_o`  out  1  a stop bit sampled low.
- `valid_o`  out  1  FIFO head valid.
- `ready_i`  in  1  consumer accepts the head.
- `overflow_o`  out  1  sticky: a byte was dropped.
- `fill_o`  out  $clog2(FifoDepth)+1  FIFO occupancy.

## Operation
- **Synchronizer.** 2-FF synchronizer on `rx_i`, both flops reset to 1. All decoding uses the synchronized value `rxs`.
- **Tick generator.** The counter runs only while the FSM is not in IDLE. It pulses `tick` every `div_i+1` cycles. It reloads to 0 on the IDLE→START transition.
- **FSM states and transitions.**
  - IDLE: falling edge on `rxs` → START.
  - START: at tick `Oversample/2`, if `rxs`=1 this is a glitch → IDLE; otherwise → DATA.
  - DATA: after `DataBits` samples → PARITY if parity is enabled, else → STOP.
  - PARITY: one sample, then → STOP.
  - STOP: `StopBits` samples, then → IDLE.
- **Sampling.** After START, every sample is taken `Oversample` ticks after the previous one (bit centre).
- **Parity.** Even: the XOR of the data bits and the parity bit must be 0. Odd: it must be 1.
- **Stop bits.** `frame_err` is set if any stop sample is 0. The FSM returns to IDLE immediately after the last stop sample, so a new start edge is detected from the next cycle.
- **Push.** On the last stop sample, push `{eol, perr, ferr, data}`. Errored bytes are still pushed.
- **EOL rule.**
  - `eol`=1 if `data==LineChar`, or if the line counter equals `MaxLineLen-1`.
  - The counter resets to 0 on an eol push; otherwise it increments on every push.
  - Dropped bytes do not advance the counter.
- **FIFO full.** A push is dropped and `overflow_o` is set, unless a pop happens in the same cycle. In that case the push is accepted and `fill_o` stays unchanged.
- **Stream port.** Pop occurs when `valid_o & ready_i`. `data_o`/flags are stable while `valid_o & !ready_i`.
- **clear_i.** Empties the FIFO, clears `overflow_o`, zeroes the line counter, and forces the FSM to IDLE. It has priority over a same-cycle push or pop.

## Timing
- **Reset values.** `valid_o`=0, `data_o`=0, all flags=0, `overflow_o`=0, `fill_o`=0. FSM in IDLE, synchronizer at 1.
- **Reset mid-frame.** The partial byte is discarded. There is no output activity until the next falling edge after reset is released.
- **Start detection.** 2 cycles from an `rx_i` fall to IDLE→START.
- **Latency.** `valid_o` rises 1 cycle after the last stop sample (registered FIFO write) when the FIFO was empty.
- **Pop.** `fill_o` updates in the cycle after the push or pop.
- **Frame length.** Total frame ≈ `(div_i+1)*Oversample*(1+DataBits+P+StopBits)` cycles, truncated by half a bit at the end.

## Structure
- **Package `uart_line_rx_pkg`.**
  - `parity_e` (`PAR_NONE`, `PAR_EVEN`, `PAR_ODD`).
  - `rx_state_e` (IDLE, START, DATA, PARITY, STOP).
  - `rx_entry_t` struct: `eol`, `perr`, `ferr`, `data[7:0]`.
- **Sub-module `uart_line_rx_fifo`.** Parametrised on depth and entry type. Owns the full/empty logic, the simultaneous push/pop rule and the clear behaviour, with the same clock/reset ports.

## Test plan
All scenarios use a 20 MHz clock and `div_i`=9, giving 10 cycles per tick and 160 cycles per bit.
- **Plain line.** Send "Hi\n" (0x48 0x69 0x0A), 8N1, `ready_i`=1 → three pops with data 48/69/0A. `eol_o`=1 only on 0x0A. All error flags 0.
- **Odd parity, 2 stop bits.** Send 0x55 with a correct parity bit, then 0x55 with a flipped parity bit → first byte `parity_err_o`=0, second `parity_err_o`=1. Both are delivered.
- **Framing and glitch.** Drive a stop bit low → `frame_err_o`=1. Then a 40-cycle low glitch on an idle line → no push, FSM returns to IDLE.
- **Forced line break.** `MaxLineLen`=80; send 81 'A' bytes with no LF → `eol_o`=1 on the 80th byte, 0 on the 81st.
- **Overflow and clear.** `FifoDepth`=4, `ready_i`=0; send 6 bytes → `fill_o`=4, `overflow_o`=1, and the first 4 bytes are retained in order. Pulse `clear_i` → `fill_o`=0, `overflow_o`=0.
- **Reset mid-operation.** Assert `rst_i` during the data bits of byte 2 → no partial byte is delivered. All outputs return to their reset values the same cycle (asynchronous). A byte sent after release is received correctly.
